// File: rtl/bidir_host_pkg.sv
// Shared definitions for the bidir host stage and its counter-stage partner.
// Holds the FSM state type and the default bus/count widths.
package bidir_host_pkg;

    localparam int unsigned BIDIR_WIDTH = 5;
    localparam int unsigned BIDIR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } host_state_e;

endpackage

// File: rtl/bidir_host_stats.sv
// Capture-statistics accumulator for the bidir host: last sample, running max,
// saturating count of zero samples and a sticky out-of-range flag.
module bidir_host_stats #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    input  logic             clear,
    input  logic [WIDTH-1:0] ld_q,
    output logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] max_val,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             err
);

    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;
    logic             err_q, err_d;

    always_comb begin
        last_d = last_q;
        max_d  = max_q;
        wrap_d = wrap_q;
        err_d  = err_q;
        if (clear) begin
            last_d = '0;
            max_d  = '0;
            wrap_d = '0;
            err_d  = 1'b0;
        end else if (sample_valid) begin
            last_d = sample;
            if (sample > max_q) begin
                max_d = sample;
            end
            // A zero sample marks one wrap of the counter stage; hold at all-ones.
            if ((sample == '0) && (wrap_q != '1)) begin
                wrap_d = wrap_q + CNT_W'(1);
            end
            if (sample > ld_q) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            max_q  <= '0;
            wrap_q <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            max_q  <= max_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign last_val = last_q;
    assign max_val  = max_q;
    assign wrap_cnt = wrap_q;
    assign err      = err_q;

endmodule

// File: rtl/bidir_host.sv
// Bus-owner stage of the bidirectional counter port: drives the load value while
// en is low, then releases the bus and samples the counter's returned values.
module bidir_host
    import bidir_host_pkg::*;
#(
    parameter int unsigned WIDTH    = BIDIR_WIDTH,
    parameter int unsigned CNT_W    = BIDIR_CNT_W,
    parameter int unsigned LOAD_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] bidir,
    output logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic [CNT_W-1:0] run_len,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] max_val,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             err
);

    localparam int unsigned LC_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

    host_state_e      state_q, state_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [LC_W-1:0]  lcnt_q, lcnt_d;
    logic             stats_clear;
    logic             sample_valid;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        busy_d      = busy_q;
        ld_d        = ld_q;
        rem_d       = rem_q;
        lcnt_d      = lcnt_q;
        stats_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ld_d        = load_val;
                    rem_d       = (run_len == '0) ? CNT_W'(1) : run_len;
                    lcnt_d      = LC_W'(LOAD_CYC - 1);
                    busy_d      = 1'b1;
                    stats_clear = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // en rises on the same edge as the state change, so the bus hands
                // over with no turnaround cycle.
                if (lcnt_q == '0) begin
                    en_d    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    lcnt_d = lcnt_q - LC_W'(1);
                end
            end
            ST_RUN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    en_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ld_q    <= '0;
            rem_q   <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ld_q    <= ld_d;
            rem_q   <= rem_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign bidir        = en_q ? {WIDTH{1'bz}} : ld_q;
    assign en           = en_q;
    assign busy         = busy_q;
    assign done         = (state_q == ST_DONE);
    assign sample_valid = (state_q == ST_RUN);

    bidir_host_stats #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample      (bidir),
        .sample_valid(sample_valid),
        .clear       (stats_clear),
        .ld_q        (ld_q),
        .last_val    (last_val),
        .max_val     (max_val),
        .wrap_cnt    (wrap_cnt),
        .err         (err)
    );

endmodule

// File: tb/tb_bidir_host.sv
// Self-checking bench for bidir_host: a transaction-level model predicts timing
// and statistics every cycle; directed scenarios add hand-computed expectations.
module tb_bidir_host;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] load_val;
    logic [7:0] run_len;
    logic       en, busy, done, err;
    logic [4:0] last_val, max_val;
    logic [7:0] wrap_cnt;
    logic [4:0] tb_val;
    wire  [4:0] bus;

    // Counter-stage stand-in: drives the bus only while the host has released it.
    assign bus = en ? tb_val : 5'bz;

    bidir_host #(
        .WIDTH   (5),
        .CNT_W   (8),
        .LOAD_CYC(L)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bidir   (bus),
        .en      (en),
        .start   (start),
        .load_val(load_val),
        .run_len (run_len),
        .busy    (busy),
        .done    (done),
        .last_val(last_val),
        .max_val (max_val),
        .wrap_cnt(wrap_cnt),
        .err     (err)
    );

    always #5 clk = ~clk;

    logic [4:0] samp [0:255];
    int seq_cnt [8] = '{1, 1, 2, 3, 0, 1, 2, 3};

    // Transaction model: cycle index since the accept edge, latched ld and length,
    // and how many samples have been consumed so far.
    logic       m_active = 1'b0;
    int         m_k      = 0;
    int         m_n      = 1;
    int         m_used   = 0;
    logic [4:0] m_ld     = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_n      <= 1;
            m_used   <= 0;
            m_ld     <= 5'd0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_ld     <= load_val;
                m_n      <= (run_len == 8'd0) ? 1 : int'(run_len);
                m_used   <= 0;
            end
        end else begin
            if (m_k >= L && m_k < L + m_n) m_used <= m_used + 1;
            if (m_k == L + m_n) m_active <= 1'b0;
            else m_k <= m_k + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int en_cycles = 0;
    int done_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_stats(input int used, output logic [4:0] l, output logic [4:0] mx,
                                      output logic [7:0] w, output logic e);
        l = 5'd0; mx = 5'd0; w = 8'd0; e = 1'b0;
        for (int i = 0; i < used; i++) begin
            l = samp[i];
            if (samp[i] > mx) mx = samp[i];
            if (samp[i] == 5'd0 && w != 8'hFF) w = w + 8'd1;
            if (samp[i] > m_ld) e = 1'b1;
        end
    endfunction

    task automatic compare();
        logic [4:0] el, em;
        logic [7:0] ew;
        logic       ee;
        exp_stats(m_used, el, em, ew, ee);
        chk("en", 32'(en), 32'(m_active && m_k >= L && m_k < L + m_n));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_active && m_k == L + m_n));
        chk("last_val", 32'(last_val), 32'(el));
        chk("max_val", 32'(max_val), 32'(em));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(ew));
        chk("err", 32'(err), 32'(ee));
        if (!en) begin
            chk("bus_known", 32'($isunknown(bus)), 32'd0);
            chk("bus_host_drive", 32'(bus), 32'(m_ld));
        end else begin
            chk("bus_counter_drive", 32'(bus), 32'(tb_val));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        if (en) en_cycles++;
        if (done) done_pulses++;
        if (m_active && m_k >= L && m_k < L + m_n) tb_val = samp[m_k - L];
        else tb_val = 5'd0;
    endtask

    // Runs one transaction from a negedge; cyc is the cycle (accept cycle = 1) where done is seen.
    task automatic run_txn(input logic [4:0] lv, input logic [7:0] rl, input bit spam, output int cyc);
        bit finished = 1'b0;
        cyc = -1;
        load_val = lv;
        run_len  = rl;
        start    = 1'b1;
        for (int idx = 1; idx <= 600; idx++) begin
            tick();
            if (done && cyc < 0) cyc = idx;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            start = spam;
            if (spam) begin
                load_val = ~lv;
                run_len  = 8'd3;
            end
        end
        start = 1'b0;
        chk("txn_complete", 32'(finished), 32'd1);
    endtask

    initial begin
        int cyc, en0, d0;
        rst_n = 1'b0; start = 1'b0; load_val = 5'd0; run_len = 8'd0; tb_val = 5'd0;
        for (int i = 0; i < 256; i++) samp[i] = 5'd0;

        for (int i = 0; i < 3; i++) tick();
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_bus", 32'(bus), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Counter-stage pairing: load 3, eight samples.
        for (int i = 0; i < 8; i++) samp[i] = 5'(seq_cnt[i]);
        en0 = en_cycles; d0 = done_pulses;
        run_txn(5'd3, 8'd8, 1'b0, cyc);
        chk("s1_done_cycle", 32'(cyc), 32'd11);
        chk("s1_en_cycles", 32'(en_cycles - en0), 32'd8);
        chk("s1_done_pulses", 32'(done_pulses - d0), 32'd1);
        chk("s1_last", 32'(last_val), 32'd3);
        chk("s1_max", 32'(max_val), 32'd3);
        chk("s1_wrap", 32'(wrap_cnt), 32'd1);
        chk("s1_err", 32'(err), 32'd0);

        // Zero load value: every sample is zero.
        for (int i = 0; i < 8; i++) samp[i] = 5'd0;
        run_txn(5'd0, 8'd5, 1'b0, cyc);
        chk("s2_wrap", 32'(wrap_cnt), 32'd5);
        chk("s2_max", 32'(max_val), 32'd0);
        chk("s2_err", 32'(err), 32'd0);

        // Out-of-range samples set err, which holds through IDLE.
        for (int i = 0; i < 8; i++) samp[i] = 5'd7;
        run_txn(5'd4, 8'd3, 1'b0, cyc);
        chk("s3_err_set", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("s3_err_sticky", 32'(err), 32'd1);
        samp[0] = 5'd1; samp[1] = 5'd2;
        run_txn(5'd4, 8'd2, 1'b0, cyc);
        chk("s3_err_cleared", 32'(err), 32'd0);
        chk("s3_last", 32'(last_val), 32'd2);

        // start held high throughout a transaction with different inputs.
        samp[0] = 5'd2; samp[1] = 5'd4; samp[2] = 5'd1;
        d0 = done_pulses;
        run_txn(5'd4, 8'd3, 1'b1, cyc);
        chk("s4_done_pulses", 32'(done_pulses - d0), 32'd1);
        chk("s4_done_cycle", 32'(cyc), 32'd6);
        chk("s4_last", 32'(last_val), 32'd1);
        chk("s4_max", 32'(max_val), 32'd4);
        chk("s4_err", 32'(err), 32'd0);

        // run_len of zero gives a single RUN cycle.
        samp[0] = 5'd5;
        en0 = en_cycles;
        run_txn(5'd6, 8'd0, 1'b0, cyc);
        chk("s5_en_cycles", 32'(en_cycles - en0), 32'd1);
        chk("s5_done_cycle", 32'(cyc), 32'd4);
        chk("s5_last", 32'(last_val), 32'd5);

        // Asynchronous reset in the middle of RUN.
        for (int i = 0; i < 8; i++) samp[i] = 5'(seq_cnt[i]);
        load_val = 5'd3; run_len = 8'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("s6_in_run", 32'(en), 32'd1);
        d0 = done_pulses;
        rst_n = 1'b0;
        #1;
        chk("s6_async_en", 32'(en), 32'd0);
        chk("s6_async_bus", 32'(bus), 32'd0);
        chk("s6_async_busy", 32'(busy), 32'd0);
        chk("s6_async_stats", 32'({last_val, max_val, wrap_cnt, err}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk("s6_no_done", 32'(done_pulses - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
